md_array_packer: RTL and testbench



---
 rtl/md_array_packer_pkg.sv | 18 +
 rtl/md_array_packer.sv | 120 ++++++++++++
 tb/tb_md_array_packer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_array_packer_pkg.sv
// Shared definitions for the packed-frame assembler: default dimensions,
// fill state encoding and the default frame layout.
package md_array_pkg;

    localparam int N_ROWS_DEF = 3;
    localparam int N_COLS_DEF = 2;
    localparam int ELEM_W_DEF = 8;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } fill_state_t;

    // Modules with non-default dimensions declare the same shape locally.
    typedef logic [N_ROWS_DEF-1:0][N_COLS_DEF-1:0][ELEM_W_DEF-1:0] frame_def_t;

endpackage

// File: rtl/md_array_packer.sv
// Serial-to-packed assembler: elements stream in row-major order into a fill
// buffer; completed frames move to an output register with valid/ready.
module md_array_packer
    import md_array_pkg::*;
#(
    parameter int N_ROWS = N_ROWS_DEF,
    parameter int N_COLS = N_COLS_DEF,
    parameter int ELEM_W = ELEM_W_DEF
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic                                       i_in_valid,
    output logic                                       o_in_ready,
    input  logic [ELEM_W-1:0]                          i_in_elem,
    input  logic                                       i_in_abort,
    output logic                                       o_out_valid,
    input  logic                                       i_out_ready,
    output logic [N_ROWS-1:0][N_COLS-1:0][ELEM_W-1:0]  o_out_frame,
    output fill_state_t                                o_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and o_in_ready is a function of state only.

    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

    typedef logic [N_ROWS-1:0][N_COLS-1:0][ELEM_W-1:0] frame_t;

    fill_state_t r_state;
    fill_state_t w_state_nxt;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    frame_t r_fill_buf;
    frame_t r_out_frame;
    frame_t w_frame_last;
    logic r_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_last;
    logic w_out_free;
    logic w_load_direct;
    logic w_load_full;

    always_comb begin
        w_in_ready    = (r_state == FILLING);
        w_accept      = i_in_valid && w_in_ready && !i_in_abort;
        w_last        = (r_row == ROW_LAST) && (r_col == COL_LAST);
        w_out_free    = !r_out_valid || i_out_ready;
        w_load_direct = w_accept && w_last && w_out_free;
        w_load_full   = (r_state == FULL) && w_out_free;
        // Fill buffer with the incoming element merged in, so the last
        // element of a frame can bypass straight into the output register.
        w_frame_last  = r_fill_buf;
        w_frame_last[r_row][r_col] = i_in_elem;
        w_state_nxt   = r_state;
        case (r_state)
            INIT:    w_state_nxt = FILLING;
            FILLING: if (w_accept && w_last && !w_out_free) w_state_nxt = FULL;
            FULL:    if (w_out_free) w_state_nxt = FILLING;
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort only matters while filling; in FULL the counters already sit at 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (r_state == FILLING) begin
            if (i_in_abort) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_accept) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= w_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fill_buf <= '0;
        end else if (w_accept) begin
            r_fill_buf <= w_frame_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_frame <= '0;
        end else if (w_load_direct || w_load_full) begin
            r_out_valid <= 1'b1;
            r_out_frame <= w_load_full ? r_fill_buf : w_frame_last;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_frame = r_out_frame;
    assign o_state     = r_state;

endmodule

// File: tb/tb_md_array_packer.sv
// Bench for md_array_packer: directed steps plus a random phase, with a
// scoreboard queue of expected frames checked at each output transfer.
module tb_md_array_packer;
    import md_array_pkg::*;

    logic clk;
    logic rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_elem;
    logic        in_abort;
    logic        out_valid;
    logic        out_ready;
    logic [2:0][1:0][7:0] out_frame;
    fill_state_t state;

    logic        v1;
    logic        rdy1;
    logic [3:0]  e1;
    logic        ov1;
    logic        or1;
    logic [0:0][0:0][3:0] f1;
    fill_state_t st1;

    int errors = 0;
    int checks = 0;

    logic [47:0] exp_q[$];
    logic [7:0]  mbuf[6];
    int          mcnt = 0;
    logic        prev_hold = 1'b0;
    logic [47:0] prev_frame = '0;
    logic        rand_done = 1'b0;

    md_array_packer dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_elem(in_elem),
        .i_in_abort(in_abort),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_frame(out_frame),
        .o_state(state)
    );

    md_array_packer #(.N_ROWS(1), .N_COLS(1), .ELEM_W(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(v1), .o_in_ready(rdy1), .i_in_elem(e1),
        .i_in_abort(1'b0),
        .o_out_valid(ov1), .i_out_ready(or1), .o_out_frame(f1),
        .o_state(st1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // scoreboard model and output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_frame", 64'(out_frame), 64'(prev_frame));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 64'(out_frame), 64'hDEAD);
                end else begin
                    check("sb_frame", 64'(out_frame), 64'(exp_q.pop_front()));
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_frame = out_frame;
            if (in_valid && in_ready) begin
                if (in_abort) begin
                    mcnt = 0;
                end else begin
                    mbuf[mcnt] = in_elem;
                    mcnt++;
                    if (mcnt == 6) begin
                        logic [47:0] fr;
                        for (int i = 0; i < 6; i++) fr[8*i +: 8] = mbuf[i];
                        exp_q.push_back(fr);
                        mcnt = 0;
                    end
                end
            end
        end
    end

    // driver: present one element, return just after the edge that took it
    task automatic send(input logic [7:0] e);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_elem  = e;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_elem = '0; in_abort = 1'b0; out_ready = 1'b0;
        v1 = 1'b0; e1 = '0; or1 = 1'b1;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_frame", 64'(out_frame), 64'd0);
        check("rst_state", 64'(state), 64'(INIT));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("init_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("filling_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // first frame, output free
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(8'(i));
        in_valid = 1'b0;
        @(negedge clk);
        check("f1_valid", 64'(out_valid), 64'd1);
        check("f1_frame", 64'(out_frame), 64'h050403020100);
        check("f1_00", 64'(out_frame[0][0]), 64'd0);
        check("f1_10", 64'(out_frame[1][0]), 64'd2);
        check("f1_21", 64'(out_frame[2][1]), 64'd5);
        @(posedge clk); #1;
        idle(1);

        // backpressure: two frames with the output stalled
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(8'(i));
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_frame", 64'(out_frame), 64'h050403020100);
        check("bp_state", 64'(state), 64'(FULL));
        @(posedge clk); #1;
        idle(2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_frame2", 64'(out_frame), 64'h0B0A09080706);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(2);

        // abort on element 3 drops it and the partial frame
        for (int i = 0; i < 3; i++) send(8'(i));
        in_abort = 1'b1;
        in_valid = 1'b1;
        in_elem  = 8'd3;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_abort = 1'b0;
        for (int i = 10; i < 16; i++) send(8'(i));
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_frame", 64'(out_frame), 64'h0F0E0D0C0B0A);
        @(posedge clk); #1;
        idle(2);

        // asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) send(8'(i));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        mcnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_init_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send(8'(i));
        in_valid = 1'b0;
        @(negedge clk);
        check("arst_frame", 64'(out_frame), 64'h050403020100);
        @(posedge clk); #1;
        idle(2);

        // 1x1 frame: every element is a frame, output one cycle behind
        for (int k = 1; k <= 8; k++) begin
            v1 = 1'b1;
            e1 = 4'(k);
            @(negedge clk);
            check("one_ready", 64'(rdy1), 64'd1);
            if (k > 1) begin
                check("one_valid", 64'(ov1), 64'd1);
                check("one_frame", 64'(f1), 64'(k - 1));
            end
            @(posedge clk); #1;
        end
        v1 = 1'b0;
        @(negedge clk);
        check("one_last", 64'(f1), 64'd8);
        @(posedge clk); #1;

        // random traffic over 1000 frames
        fork
            begin
                for (int f = 0; f < 1000; f++) begin
                    for (int e = 0; e < 6; e++) begin
                        send(8'($urandom_range(0, 255)));
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    end
                end
                in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        idle(2);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("rand_partial", 64'(mcnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
